// File: rtl/tcm_capture_pkg.sv
// Shared types and constants for the AXI-Stream TCM capture block.
// State encoding, drop-counter width and memory depth helper.
package tcm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  localparam int DROP_CNT_W = 16;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/tcm_sdp_ram.sv
// Simple dual-port TCM: one write port, one read-first registered read port.
// Array is left unreset so tools map it onto block RAM.
module tcm_sdp_ram
  import tcm_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [depth_of(ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Output register holds its value when idle; a same-cycle write returns old data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tcm_axis_capture.sv
// AXI-Stream frame capture into TCM with start/abort/done control.
// Optional drop counter: define TCM_AXIS_CAPTURE_DROP_CNT_EN.
module tcm_axis_capture
  import tcm_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESET,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  input  logic                  S_AXIS_TLAST,
  output logic                  S_AXIS_TREADY,
  input  logic                  ctrl_start,
  input  logic                  ctrl_abort,
  input  logic                  ctrl_circ,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic [ADDR_WIDTH:0]   sts_count,
  output logic [ADDR_WIDTH-1:0] sts_wr_ptr,
  output logic                  sts_last,
  output logic                  sts_wrapped,
  output logic [DROP_CNT_W-1:0] sts_drop_cnt
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  cap_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  last_q, last_d;
  logic                  wrap_q, wrap_d;
  logic                  circ_q, circ_d;
  logic                  rd_valid_q;

  logic full;
  logic tready;
  logic accept;
  logic start_ok;

  assign full     = (count_q == DEPTH_C);
  // Reset gates the handshake so an abandoned frame writes nothing.
  assign tready   = (state_q == ST_CAPTURE) & ~S_AXIS_ARESET
                  & ~ctrl_abort & ~(~circ_q & full);
  assign accept   = S_AXIS_TVALID & tready;
  assign start_ok = (state_q != ST_CAPTURE) & ctrl_start & ~ctrl_abort;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    wrap_d   = wrap_q;
    circ_d   = circ_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d  = ST_CAPTURE;
          wr_ptr_d = '0;
          count_d  = '0;
          last_d   = 1'b0;
          wrap_d   = 1'b0;
          circ_d   = ctrl_circ;
        end
      end
      ST_CAPTURE: begin
        if (ctrl_abort) begin
          state_d = ST_DONE;
          last_d  = 1'b0;
        end else if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = full ? count_q : count_q + 1'b1;
          if (circ_q && full) begin
            wrap_d = 1'b1;
          end
          if (S_AXIS_TLAST) begin
            state_d = ST_DONE;
            last_d  = 1'b1;
          end else if (!circ_q && count_q == DEPTH_C - 1'b1) begin
            state_d = ST_DONE;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= 1'b0;
      wrap_q     <= 1'b0;
      circ_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      wrap_q     <= wrap_d;
      circ_q     <= circ_d;
      rd_valid_q <= rd_en;
    end
  end

`ifdef TCM_AXIS_CAPTURE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (start_ok) begin
      drop_d = '0;
    end else if (state_q != ST_IDLE && S_AXIS_TVALID && !tready
                 && drop_q != {DROP_CNT_W{1'b1}}) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign sts_drop_cnt = drop_q;
`else
  assign sts_drop_cnt = '0;
`endif

  tcm_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (S_AXIS_ACLK),
    .rst_i   (S_AXIS_ARESET),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (S_AXIS_TDATA),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign S_AXIS_TREADY = tready;
  assign rd_valid      = rd_valid_q;
  assign sts_busy      = (state_q == ST_CAPTURE);
  assign sts_done      = (state_q == ST_DONE);
  assign sts_count     = count_q;
  assign sts_wr_ptr    = wr_ptr_q;
  assign sts_last      = last_q;
  assign sts_wrapped   = wrap_q;

endmodule

// File: tb/tb_tcm_axis_capture.sv
// Directed self-checking bench for tcm_axis_capture (DATA_WIDTH=32, ADDR_WIDTH=5).
// Drop-count expectations follow TCM_AXIS_CAPTURE_DROP_CNT_EN.
module tb_tcm_axis_capture;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef TCM_AXIS_CAPTURE_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          areset;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic          start;
  logic          abort;
  logic          circ;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr;
  logic          last;
  logic          wrapped;
  logic [15:0]   drop;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tcm_axis_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (areset),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TREADY (tready),
    .ctrl_start    (start),
    .ctrl_abort    (abort),
    .ctrl_circ     (circ),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .sts_busy      (busy),
    .sts_done      (done),
    .sts_count     (count),
    .sts_wr_ptr    (wr_ptr),
    .sts_last      (last),
    .sts_wrapped   (wrapped),
    .sts_drop_cnt  (drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic c);
    start = 1'b1;
    circ  = c;
    tick();
    start = 1'b0;
    circ  = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l,
                      output logic acc);
    tdata  = d;
    tvalid = 1'b1;
    tlast  = l;
    #1;
    acc = tready;
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a,
                        input logic [DW-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_vld"}, rd_valid, 1);
    chk(tag, rd_data, exp);
  endtask

  initial begin
    logic acc;
    int   n_acc;
    int   k;
    areset  = 1'b1;
    tdata   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    circ    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_tready", tready, 0);
    chk("rst_rdvalid", rd_valid, 0);
    chk("rst_rddata", rd_data, 0);
    areset = 1'b0;
    tick();

    // basic single-shot frame
    do_start(1'b0);
    chk("b_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      beat(32'h100 + i, i == 9, acc);
      chk("b_ready", acc, 1);
    end
    chk("b_done", done, 1);
    chk("b_count", count, 10);
    chk("b_last", last, 1);
    chk("b_wrptr", wr_ptr, 10);
    chk("b_tready", tready, 0);
    for (int a = 0; a < 10; a++) begin
      rd_chk("b_rd", AW'(a), 32'h100 + a);
    end
    tick();
    chk("b_rdvld_low", rd_valid, 0);
    chk("b_rd_hold", rd_data, 32'h109);

    // single-shot overflow
    do_start(1'b0);
    chk("o_done_clr", done, 0);
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      beat(32'h200 + i, 1'b0, acc);
      if (acc) n_acc++;
    end
    chk("o_acc", n_acc, 32);
    chk("o_done", done, 1);
    chk("o_count", count, 32);
    chk("o_last", last, 0);
    chk("o_drop", drop, DROP_EN ? 8 : 0);
    rd_chk("o_rd31", 5'd31, 32'h21F);

    // circular wrap
    do_start(1'b1);
    for (int i = 0; i < 40; i++) begin
      beat(i, i == 39, acc);
    end
    chk("c_done", done, 1);
    chk("c_wrapped", wrapped, 1);
    chk("c_count", count, 32);
    chk("c_wrptr", wr_ptr, 8);
    chk("c_last", last, 1);
    rd_chk("c_rd0", 5'd0, 32);
    rd_chk("c_rd7", 5'd7, 39);
    rd_chk("c_rd8", 5'd8, 8);

    // abort
    do_start(1'b0);
    chk("a_wrap_clr", wrapped, 0);
    for (int i = 0; i < 5; i++) begin
      beat(32'h300 + i, 1'b0, acc);
    end
    abort = 1'b1;
    beat(32'hDEAD, 1'b0, acc);
    abort = 1'b0;
    chk("a_ready", acc, 0);
    chk("a_count", count, 5);
    chk("a_done", done, 1);
    chk("a_last", last, 0);
    chk("a_wrptr", wr_ptr, 5);
    chk("a_drop", drop, DROP_EN ? 1 : 0);
    rd_chk("a_rd5", 5'd5, 37);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("a_norearm_done", done, 1);
    chk("a_norearm_busy", busy, 0);

    // backpressure and gaps
    do_start(1'b0);
    k = 0;
    for (int cyc = 0; cyc < 300 && k < 12; cyc++) begin
      tvalid = 1'($urandom_range(0, 1));
      tdata  = 32'h400 + k;
      tlast  = (k == 11);
      #1;
      if (tvalid && tready) k++;
      tick();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("g_beats", k, 12);
    chk("g_done", done, 1);
    chk("g_count", count, 12);
    chk("g_last", last, 1);
    for (int a = 0; a < 12; a++) begin
      rd_chk("g_rd", AW'(a), 32'h400 + a);
    end
    do_start(1'b0);
    chk("s_busy", busy, 1);
    chk("s_done", done, 0);
    chk("s_count", count, 0);
    chk("s_wrptr", wr_ptr, 0);
    chk("s_last", last, 0);
    chk("s_drop", drop, 0);
    for (int i = 0; i < 3; i++) begin
      beat(32'h500 + i, i == 2, acc);
    end
    chk("s_count3", count, 3);
    chk("s_done3", done, 1);

    // reset mid-capture
    do_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(32'h600 + i, 1'b0, acc);
    end
    chk("r_count4", count, 4);
    areset = 1'b1;
    tdata  = 32'hBAD;
    tvalid = 1'b1;
    #1;
    chk("r_tready_inrst", tready, 0);
    tick();
    areset = 1'b0;
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_count", count, 0);
    chk("r_wrptr", wr_ptr, 0);
    chk("r_last", last, 0);
    chk("r_wrapped", wrapped, 0);
    chk("r_drop", drop, 0);
    chk("r_rdvalid", rd_valid, 0);
    chk("r_rddata", rd_data, 0);
    chk("r_tready", tready, 0);
    tick();
    tick();
    tvalid = 1'b0;
    rd_chk("r_rd4", 5'd4, 32'h404);
    rd_chk("r_rd3", 5'd3, 32'h603);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tcm_axis_capture.md
Name: tcm_axis_capture

Overview:
- Parametrised AXI-Stream slave that captures one frame of stream beats into an inferred tightly-coupled memory (TCM).
- Successor to the fixed 32x32 capture buffer. Adds configurable width and depth, a start/abort/done handshake, TLAST frame termination, single-shot or circular mode, and a registered read port with a valid flag.
- Sits between an AXI-Stream source (DMA or peripheral) and the AXI-Lite register block that drives control and reads back results.

Parameters:
- DATA_WIDTH, 32, TDATA and memory word width in bits (8..128).
- ADDR_WIDTH, 5, TCM address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- S_AXIS_ACLK  in  1  sole clock.
- S_AXIS_ARESET  in  1  synchronous reset, active-high.
- S_AXIS_TDATA  in  DATA_WIDTH  stream data.
- S_AXIS_TVALID  in  1  stream valid.
- S_AXIS_TLAST  in  1  end of frame.
- S_AXIS_TREADY  out  1  stream ready.
- ctrl_start  in  1  single-cycle pulse that arms a capture.
- ctrl_abort  in  1  single-cycle pulse that ends a capture.
- ctrl_circ  in  1  mode: 0 = single-shot, 1 = circular; sampled on the accepted start.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data valid; 1 cycle after rd_en.
- sts_busy  out  1  state is CAPTURE.
- sts_done  out  1  state is DONE.
- sts_count  out  ADDR_WIDTH+1  beats stored, saturates at DEPTH.
- sts_wr_ptr  out  ADDR_WIDTH  next write address; in circular mode this is the oldest entry.
- sts_last  out  1  capture ended by TLAST.
- sts_wrapped  out  1  circular capture overwrote data.
- sts_drop_cnt  out  16  see Optional Feature.

Behaviour:
- Reset
  - State = IDLE.
  - TREADY = 0.
  - rd_data = 0, rd_valid = 0.
  - All sts_* outputs = 0.
  - Memory contents are not reset.
  - Reset mid-capture abandons the frame; no further writes occur.
- State machine states: IDLE, CAPTURE, DONE.
- IDLE / DONE
  - TREADY = 0.
  - ctrl_start & ~ctrl_abort moves to CAPTURE and clears wr_ptr, count, last, wrapped and drop_cnt. It also latches ctrl_circ.
  - ctrl_abort while in IDLE or DONE has no effect, and it wins over a simultaneous start.
  - sts_done = 1 only in DONE, and holds until the next accepted start.
- CAPTURE
  - S_AXIS_TREADY is combinational: TREADY = ~ctrl_abort & ~(single-shot & count==DEPTH).
  - A beat is accepted when TVALID & TREADY.
  - On an accepted beat, at the same edge:
    - mem[wr_ptr] <= TDATA.
    - wr_ptr <= wr_ptr+1, modulo DEPTH.
    - count <= min(count+1, DEPTH).
  - Accepted beat with TLAST: go to DONE with sts_last = 1. TLAST takes priority over the full check.
  - Single-shot: the accepted beat that makes count==DEPTH goes to DONE (sts_last = TLAST of that beat). No beat is ever accepted beyond DEPTH.
  - Circular: wr_ptr wraps to 0 and keeps writing. The first write at count==DEPTH sets sts_wrapped. The capture runs until TLAST or abort.
  - ctrl_abort: go to DONE with sts_last = 0. No beat is accepted in that cycle.
  - ctrl_start is ignored while in CAPTURE.
  - A zero-length frame never ends the capture; a capture only ends on an accepted beat or on abort.
- Read port
  - Usable in any state.
  - rd_en at cycle N gives rd_data = mem[rd_addr] and rd_valid = 1 at cycle N+1. rd_valid is 0 otherwise.
  - rd_data holds its last value when rd_en = 0.
  - Same-address read and write in one cycle return the old data (read-first).

Optional Feature:
- Macro: TCM_AXIS_CAPTURE_DROP_CNT_EN.
- Defined:
  - sts_drop_cnt counts cycles with TVALID=1 & TREADY=0 while state is CAPTURE or DONE.
  - Counted cases are single-shot full, abort cycle, and post-frame traffic.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on an accepted start.
- Undefined: no counter logic is built and sts_drop_cnt is tied to 0.

Decomposition:
- Package tcm_capture_pkg holds:
  - the state enum (IDLE, CAPTURE, DONE);
  - the DROP_CNT_W = 16 constant;
  - the DEPTH derivation helper.
- One sub-module, tcm_sdp_ram:
  - simple dual-port RAM parametrised by DATA_WIDTH/ADDR_WIDTH;
  - one write port;
  - one read-first, 1-cycle-latency read port with registered output;
  - must infer block RAM.
- FSM, counters and status logic stay in tcm_axis_capture.

Test Plan:
- Basic frame, single-shot, ADDR_WIDTH=5: start, stream 10 beats 0x100..0x109 with TLAST on the 10th.
  - Required: DONE, count=10, sts_last=1, wr_ptr=10, TREADY=0 after.
  - Reading addresses 0..9 returns 0x100..0x109, each with rd_valid one cycle after rd_en.
- Single-shot overflow: start, stream 40 beats without TLAST.
  - Required: DONE after beat 32, count=32, sts_last=0, TREADY=0 for beats 33..40.
  - With the macro defined, sts_drop_cnt=8.
- Circular wrap: ctrl_circ=1, stream 40 beats 0..39 with TLAST on beat 39.
  - Required: sts_wrapped=1, count=32, wr_ptr=8, sts_last=1.
  - mem[0..7]=32..39 and mem[8]=8.
- Abort: start, 5 beats, then ctrl_abort coincident with TVALID.
  - Required: the abort-cycle beat is not accepted, count=5, DONE, sts_last=0.
  - A simultaneous start & abort in DONE does not rearm.
- Backpressure and gaps: TVALID toggles randomly over a 12-beat frame.
  - Required: exactly the 12 handshaked beats are stored, in order.
  - A second start clears all status and a new 3-beat frame gives count=3.
- Reset mid-capture: assert S_AXIS_ARESET after 4 beats.
  - Required: IDLE, all outputs 0, TREADY=0.
  - Subsequent TVALID writes nothing; verified by read-back of address 4 unchanged.
